// File: rtl/pr_hrav_collector_if.sv
// AXI4-Stream bundle used on every stream port of the HR-AV return-path collector.
// TUSER is fixed at 128 bits; TSTRB follows the data width.
interface pr_hrav_collector_if #(
    parameter int DATA_WIDTH = 256
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic [127:0]            tuser;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tstrb, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pr_hrav_collector.sv
// Packet-granular 3:1 AXI-Stream merger (core 0, core 1, ICAP) with source tagging,
// partial-reconfiguration decoupling and a registered 2-entry output buffer.
module pr_hrav_collector #(
    parameter int C_M_AXIS_DATA_WIDTH = 256,
    parameter int C_S_AXIS_DATA_WIDTH = 256
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                core_0_enb,
    input  logic                core_1_enb,
    pr_hrav_collector_if.slave  core0_s_axis,
    pr_hrav_collector_if.slave  core1_s_axis,
    pr_hrav_collector_if.slave  icap_s_axis,
    pr_hrav_collector_if.master m_axis
);
    localparam int W = C_M_AXIS_DATA_WIDTH;

    if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH) begin : g_width_check
        $error("pr_hrav_collector: input and output TDATA widths must match");
    end

    typedef enum logic [2:0] {IDLE, CORE0_PKT, CORE1_PKT, ICAP_PKT, ABORT} state_t;

    // Encoding doubles as the TUSER[17:16] source tag.
    typedef enum logic [1:0] {
        SRC_CORE0 = 2'b00,
        SRC_CORE1 = 2'b01,
        SRC_ICAP  = 2'b10,
        SRC_NONE  = 2'b11
    } src_t;

    typedef struct packed {
        logic [W-1:0]   data;
        logic [W/8-1:0] strb;
        logic [17:0]    user;
        logic           last;
    } beat_t;

    state_t     state;
    src_t       sel;
    logic       rr_ptr;
    logic       abort_core;
    logic       en0_meta, en0_s, en1_meta, en1_s;
    logic       live;
    logic       buf_rdy;
    logic [1:0] count, count_next;
    beat_t      mem [2];
    beat_t      push_beat;
    logic       push, pop, accept;
    logic       v0, v1;

    function automatic beat_t make_beat(input logic [W-1:0] data, input logic [W/8-1:0] strb,
                                        input logic [15:0] user, input src_t tag, input logic last);
        beat_t b;
        b.data = data;
        b.strb = strb;
        b.user = {tag, user};
        b.last = last;
        return b;
    endfunction

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en0_meta <= 1'b0;
            en0_s    <= 1'b0;
            en1_meta <= 1'b0;
            en1_s    <= 1'b0;
            live     <= 1'b0;
        end else begin
            en0_meta <= core_0_enb;
            en0_s    <= en0_meta;
            en1_meta <= core_1_enb;
            en1_s    <= en1_meta;
            live     <= 1'b1;
        end
    end

    assign v0 = core0_s_axis.tvalid & en0_s;
    assign v1 = core1_s_axis.tvalid & en1_s;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = SRC_NONE;
        unique case (state)
            IDLE: begin
                if (icap_s_axis.tvalid)  sel = SRC_ICAP;
                else if (v0 && v1)       sel = rr_ptr ? SRC_CORE1 : SRC_CORE0;
                else if (v0)             sel = SRC_CORE0;
                else if (v1)             sel = SRC_CORE1;
            end
            CORE0_PKT: if (en0_s) sel = SRC_CORE0;
            CORE1_PKT: if (en1_s) sel = SRC_CORE1;
            ICAP_PKT:  sel = SRC_ICAP;
            default:   sel = SRC_NONE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_beat = '0;
        if (state == ABORT) begin
            push           = buf_rdy;
            push_beat.user = {1'b0, abort_core, 16'h8000};
            push_beat.last = 1'b1;
        end else begin
            unique case (sel)
                SRC_CORE0: begin
                    push      = core0_s_axis.tvalid & buf_rdy;
                    push_beat = make_beat(core0_s_axis.tdata, core0_s_axis.tstrb,
                                          core0_s_axis.tuser[15:0], SRC_CORE0, core0_s_axis.tlast);
                end
                SRC_CORE1: begin
                    push      = core1_s_axis.tvalid & buf_rdy;
                    push_beat = make_beat(core1_s_axis.tdata, core1_s_axis.tstrb,
                                          core1_s_axis.tuser[15:0], SRC_CORE1, core1_s_axis.tlast);
                end
                SRC_ICAP: begin
                    push      = icap_s_axis.tvalid & buf_rdy;
                    push_beat = make_beat(icap_s_axis.tdata, icap_s_axis.tstrb,
                                          icap_s_axis.tuser[15:0], SRC_ICAP, icap_s_axis.tlast);
                end
                default: ;
            endcase
        end
    end

    assign accept = push & (state != ABORT);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            abort_core <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (push_beat.last) begin
                            if (sel != SRC_ICAP) rr_ptr <= (sel == SRC_CORE0);
                        end else begin
                            state <= (sel == SRC_CORE0) ? CORE0_PKT :
                                     (sel == SRC_CORE1) ? CORE1_PKT : ICAP_PKT;
                        end
                    end
                end
                CORE0_PKT: begin
                    if (!en0_s) begin
                        state      <= ABORT;
                        abort_core <= 1'b0;
                    end else if (accept && push_beat.last) begin
                        state  <= IDLE;
                        rr_ptr <= 1'b1;
                    end
                end
                CORE1_PKT: begin
                    if (!en1_s) begin
                        state      <= ABORT;
                        abort_core <= 1'b1;
                    end else if (accept && push_beat.last) begin
                        state  <= IDLE;
                        rr_ptr <= 1'b0;
                    end
                end
                ICAP_PKT: begin
                    if (accept && push_beat.last) state <= IDLE;
                end
                ABORT: begin
                    if (buf_rdy) begin
                        state  <= IDLE;
                        rr_ptr <= ~abort_core;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop        = (count != 2'd0) & m_axis.tready;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // NOTE: the two buffer entries are reset because entry 0 drives M_AXIS directly
    // and its data fields must read zero while in reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count   <= 2'd0;
            buf_rdy <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            count   <= count_next;
            buf_rdy <= (count_next != 2'd2);
            if (push && (pop || count == 2'd0)) mem[0] <= push_beat;
            else if (pop)                       mem[0] <= mem[1];
            if (push && !pop && count == 2'd1)  mem[1] <= push_beat;
        end
    end

    // A decoupled core is drained and discarded; live keeps TREADY low through reset.
    assign core0_s_axis.tready = live & (~en0_s | ((sel == SRC_CORE0) & buf_rdy));
    assign core1_s_axis.tready = live & (~en1_s | ((sel == SRC_CORE1) & buf_rdy));
    assign icap_s_axis.tready  = (sel == SRC_ICAP) & buf_rdy;

    assign m_axis.tvalid = (count != 2'd0);
    assign m_axis.tdata  = mem[0].data;
    assign m_axis.tstrb  = mem[0].strb;
    assign m_axis.tuser  = {110'b0, mem[0].user};
    assign m_axis.tlast  = mem[0].last;
endmodule

// File: tb/tb_pr_hrav_collector.sv
// Scoreboard bench for pr_hrav_collector: directed packets push expected beats into a
// queue; a monitor pops and compares every beat leaving M_AXIS.
module tb_pr_hrav_collector;
    localparam int W = 256;

    typedef struct {
        logic [W-1:0]   data;
        logic [W/8-1:0] strb;
        logic [127:0]   user;
        logic           last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_0_enb = 1'b1;
    logic core_1_enb = 1'b1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pr_hrav_collector_if #(.DATA_WIDTH(W)) c0_if ();
    pr_hrav_collector_if #(.DATA_WIDTH(W)) c1_if ();
    pr_hrav_collector_if #(.DATA_WIDTH(W)) icap_if ();
    pr_hrav_collector_if #(.DATA_WIDTH(W)) m_if ();

    pr_hrav_collector #(
        .C_M_AXIS_DATA_WIDTH(W),
        .C_S_AXIS_DATA_WIDTH(W)
    ) dut (
        .ACLK        (clk),
        .ARESETN     (rst_n),
        .core_0_enb  (core_0_enb),
        .core_1_enb  (core_1_enb),
        .core0_s_axis(c0_if),
        .core1_s_axis(c1_if),
        .icap_s_axis (icap_if),
        .m_axis      (m_if)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    xfer_q[$];
    int    acc_cnt[3];
    int    first_acc[3];
    logic  done5;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input int src, input int pkt, input int b);
        logic [31:0] w;
        w = {4'hA, 4'(src), 8'(pkt), 8'(b), 8'h5C};
        return {8{w}};
    endfunction

    function automatic logic [W/8-1:0] mk_strb(input int b, input logic last);
        return last ? 32'h0000_FFFF : (32'hFFFF_FFFF ^ 32'(b));
    endfunction

    function automatic logic [127:0] mk_user_in(input int pkt, input int b);
        return {{14{8'hE5}}, 8'(pkt), 8'(b)};
    endfunction

    function automatic logic [127:0] mk_user_out(input int src, input int pkt, input int b);
        return {110'b0, 2'(src), 8'(pkt), 8'(b)};
    endfunction

    task automatic expect_pkt(input int src, input int pkt, input int first, input int n, input int total);
        beat_t e;
        for (int b = first; b < first + n; b++) begin
            e.data = mk_data(src, pkt, b);
            e.strb = mk_strb(b, b == total - 1);
            e.user = mk_user_out(src, pkt, b);
            e.last = (b == total - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_abort(input int src);
        beat_t e;
        e.data = '0;
        e.strb = '0;
        e.user = {110'b0, 2'(src), 16'h8000};
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic set_src(input int src, input logic valid, input int pkt, input int b, input int total);
        logic [W-1:0]   d;
        logic [W/8-1:0] s;
        logic [127:0]   u;
        logic           l;
        d = mk_data(src, pkt, b);
        l = (b == total - 1);
        s = mk_strb(b, l);
        u = mk_user_in(pkt, b);
        case (src)
            0: begin c0_if.tvalid = valid; c0_if.tdata = d; c0_if.tstrb = s; c0_if.tuser = u; c0_if.tlast = l; end
            1: begin c1_if.tvalid = valid; c1_if.tdata = d; c1_if.tstrb = s; c1_if.tuser = u; c1_if.tlast = l; end
            default: begin
                icap_if.tvalid = valid; icap_if.tdata = d; icap_if.tstrb = s; icap_if.tuser = u; icap_if.tlast = l;
            end
        endcase
    endtask

    function automatic logic get_tready(input int src);
        case (src)
            0:       return c0_if.tready;
            1:       return c1_if.tready;
            default: return icap_if.tready;
        endcase
    endfunction

    // Presents beats first..first+n-1 of a packet; returns just after the last accept edge.
    task automatic send_beats(input int src, input int pkt, input int first, input int n, input int total);
        logic ok;
        int   waited;
        for (int b = first; b < first + n; b++) begin
            set_src(src, 1'b1, pkt, b, total);
            ok = 1'b0;
            waited = 0;
            while (!ok && waited < 2000) begin
                @(negedge clk);
                ok = get_tready(src);
                waited++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: src %0d pkt %0d beat %0d never accepted", src, pkt, b);
                set_src(src, 1'b0, pkt, b, total);
                return;
            end
            if (b == first) first_acc[src] = cyc + 1;
            @(posedge clk);
            #1;
            acc_cnt[src]++;
        end
        set_src(src, 1'b0, pkt, first + n - 1, total);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tstrb", m_if.tstrb, 0);
        check("rst_m_tuser", m_if.tuser, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_c0_tready", c0_if.tready, 0);
        check("rst_c1_tready", c1_if.tready, 0);
        check("rst_icap_tready", icap_if.tready, 0);
    endtask

    task automatic monitor();
        logic  stalled;
        beat_t held, cur, e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            cur.data = m_if.tdata;
            cur.strb = m_if.tstrb;
            cur.user = m_if.tuser;
            cur.last = m_if.tlast;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("hold_tvalid", m_if.tvalid, 1);
                check("hold_tdata", cur.data, held.data);
                check("hold_tuser", cur.user, held.user);
                check("hold_tlast", cur.last, held.last);
            end
            if (m_if.tvalid && m_if.tready) begin
                xfer_q.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tuser %0h tdata %0h, required no beat", cur.user, cur.data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_tdata", cur.data, e.data);
                    check("beat_tstrb", cur.strb, e.strb);
                    check("beat_tuser", cur.user, e.user);
                    check("beat_tlast", cur.last, e.last);
                end
            end
            stalled = m_if.tvalid && !m_if.tready;
            held = cur;
        end
    endtask

    initial begin
        int base;
        m_if.tready = 1'b1;
        for (int s = 0; s < 3; s++) set_src(s, 1'b0, 0, 0, 1);
        fork
            monitor();
        join_none

        // Reset values, then synchronizer latency on release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("sync_c0_tready_decoupled", c0_if.tready, 1);
        check("sync_icap_tready_idle", icap_if.tready, 0);
        @(posedge clk);
        #1;
        check("sync_c0_tready_coupled", c0_if.tready, 0);
        repeat (2) @(posedge clk);
        #1;

        // Single 4-beat core0 packet: 1-cycle latency, no gaps.
        xfer_q.delete();
        expect_pkt(0, 1, 0, 4, 4);
        send_beats(0, 1, 0, 4, 4);
        wait_drain("s1_drain");
        check("s1_beats", xfer_q.size(), 4);
        check("s1_latency", xfer_q[0], first_acc[0] + 1);
        check("s1_no_gap", xfer_q[3] - xfer_q[0], 3);

        // Both cores continuously: rr now prefers core1, then alternates back-to-back.
        xfer_q.delete();
        expect_pkt(1, 2, 0, 3, 3);
        expect_pkt(0, 3, 0, 3, 3);
        expect_pkt(1, 4, 0, 3, 3);
        expect_pkt(0, 5, 0, 3, 3);
        fork
            begin send_beats(0, 3, 0, 3, 3); send_beats(0, 5, 0, 3, 3); end
            begin send_beats(1, 2, 0, 3, 3); send_beats(1, 4, 0, 3, 3); end
        join
        wait_drain("s2_drain");
        check("s2_beats", xfer_q.size(), 12);
        check("s2_back_to_back", xfer_q[11] - xfer_q[0], 11);

        // ICAP arrives mid core1 packet: core1 finishes, ICAP next, then core0.
        expect_pkt(1, 6, 0, 4, 4);
        expect_pkt(2, 7, 0, 2, 2);
        expect_pkt(0, 8, 0, 2, 2);
        fork
            send_beats(1, 6, 0, 4, 4);
            begin repeat (2) @(posedge clk); #1; send_beats(2, 7, 0, 2, 2); end
            begin repeat (2) @(posedge clk); #1; send_beats(0, 8, 0, 2, 2); end
        join
        wait_drain("s3_drain");

        // core1 decoupled after beat 2 of 5: abort beat, rest discarded.
        expect_pkt(1, 9, 0, 2, 5);
        expect_abort(1);
        send_beats(1, 9, 0, 2, 5);
        core_1_enb = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("dis_c1_tready", c1_if.tready, 1);
        send_beats(1, 9, 2, 3, 5);
        wait_drain("s4_drain");
        core_1_enb = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // After the abort rr prefers core0; single-beat packets from both cores.
        expect_pkt(0, 11, 0, 1, 1);
        expect_pkt(1, 12, 0, 1, 1);
        fork
            send_beats(0, 11, 0, 1, 1);
            send_beats(1, 12, 0, 1, 1);
        join
        wait_drain("s4b_drain");

        // 100 beats under random 50% backpressure.
        for (int p = 0; p < 10; p++) begin
            expect_pkt(0, 20 + p, 0, 5, 5);
            expect_pkt(1, 40 + p, 0, 5, 5);
        end
        done5 = 1'b0;
        fork
            begin
                fork
                    for (int p = 0; p < 10; p++) send_beats(0, 20 + p, 0, 5, 5);
                    for (int p = 0; p < 10; p++) send_beats(1, 40 + p, 0, 5, 5);
                join
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = 1'($urandom_range(0, 1));
                end
                m_if.tready = 1'b1;
            end
        join
        wait_drain("s5_drain");

        // Full stall: exactly two beats buffered, then source TREADY drops.
        repeat (3) @(posedge clk);
        #1;
        m_if.tready = 1'b0;
        base = acc_cnt[0];
        expect_pkt(0, 60, 0, 3, 3);
        fork
            send_beats(0, 60, 0, 3, 3);
            begin
                repeat (6) @(negedge clk);
                check("bp_accepted", acc_cnt[0] - base, 2);
                check("bp_c0_tready", c0_if.tready, 0);
                check("bp_m_tvalid", m_if.tvalid, 1);
                @(posedge clk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        wait_drain("s5b_drain");

        // Reset mid-packet: beat 1 is lost in the flushed buffer, rr restarts at core0.
        expect_pkt(0, 70, 0, 1, 6);
        send_beats(0, 70, 0, 2, 6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("s6_flushed", exp_q.size(), 0);
        expect_pkt(0, 71, 0, 2, 2);
        expect_pkt(1, 72, 0, 2, 2);
        fork
            send_beats(0, 71, 0, 2, 2);
            send_beats(1, 72, 0, 2, 2);
        join
        wait_drain("s6_drain");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
